// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
//   - pipe_state_e : occupancy state of a stage (empty / main slot / main+skid)
//   - *_W_DEF      : default payload, control and counter widths
//   - CTRL_*       : bit positions inside the CPU control bundle so that every
//                    stage packs and unpacks the bundle the same way
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    localparam int CTRL_REG_WR     = 0;
    localparam int CTRL_MEM_REG    = 1;
    localparam int CTRL_REG_IN_SEL = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for stage performance statistics.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high clear
//   inc   - count one event this cycle
//   clear - synchronous clear (wins over inc)
//   cnt   - current count, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, a
// 2-entry skid buffer, hazard stall and branch flush. Bubbles always present
// all-zero control so they can never write the register file or memory.
// Optional macro: PIPE_STAGE_PERF_EN adds stall/bubble saturating counters.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   in_valid/in_ready    - upstream handshake (in_ready never sees out_ready)
//   in_data/in_ctrl      - upstream payload and control bundle
//   stall                - hazard hold, blocks the downstream transfer
//   flush                - kills every held entry
//   out_valid/out_ready  - downstream handshake
//   out_data/out_ctrl    - presented payload and (gated) control
//   stall_cnt/bubble_cnt - performance counters (PIPE_STAGE_PERF_EN only)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    pipe_state_e       r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_acc_in;
    logic w_acc_out;

    // in_ready is a function of registered state and flush only, which keeps
    // the ready chain between stages free of combinational loops.
    assign in_ready  = (r_state != ST_TWO) & ~flush & ~reset;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main_data;
    assign out_ctrl  = out_valid ? r_main_ctrl : '0;

    assign w_acc_in  = in_valid & in_ready;
    assign w_acc_out = out_valid & out_ready & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            // Data may go stale; only control must be cleared so a stale
            // slot can never be mistaken for a live instruction.
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc_in) begin
                        r_state     <= ST_ONE;
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (w_acc_in && w_acc_out) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                    end else if (w_acc_in) begin
                        // Downstream blocked: park the new entry behind main.
                        r_state     <= ST_TWO;
                        r_skid_data <= in_data;
                        r_skid_ctrl <= in_ctrl;
                    end else if (w_acc_out) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_acc_out) begin
                        r_state     <= ST_ONE;
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic w_stall_inc;
    logic w_bubble_inc;

    assign w_stall_inc  = out_valid & ~(out_ready & ~stall);
    assign w_bubble_inc = ~out_valid;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .clear (1'b0),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_bubble_inc),
        .clear (1'b0),
        .cnt   (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] bubble_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CTRL_W (CW)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_W  (NW)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    // Reference model: a FIFO of at most two {ctrl,data} entries plus
    // saturating event counters.
    logic [CW+DW-1:0] q[$];
    int m_stall  = 0;
    int m_bubble = 0;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic m_valid();
        return q.size() > 0;
    endfunction

    function automatic logic [DW-1:0] m_data();
        logic [CW+DW-1:0] e;
        e = (q.size() > 0) ? q[0] : '0;
        return e[DW-1:0];
    endfunction

    function automatic logic [CW-1:0] m_ctrl();
        logic [CW+DW-1:0] e;
        e = (q.size() > 0) ? q[0] : '0;
        return e[CW+DW-1:DW];
    endfunction

    function automatic logic m_ready();
        return (q.size() < 2) && !flush && !reset;
    endfunction

    // Advance one clock and update the model from the driven inputs.
    task automatic tick();
        bit ov, take_in, take_out;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            ov       = q.size() > 0;
            take_out = ov && out_ready && !stall;
            take_in  = m_ready() && in_valid;
            if (ov && !(out_ready && !stall) && m_stall < (2**NW - 1)) m_stall++;
            if (!ov && m_bubble < (2**NW - 1)) m_bubble++;
            if (flush) begin
                q.delete();
            end else begin
                if (take_out) void'(q.pop_front());
                if (take_in) q.push_back({in_ctrl, in_data});
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_ctrl = 8'h03;
        out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        q.delete(); m_stall = 0; m_bubble = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold: out_valid=%b out_ctrl=%h in_ready=%b out_data=%h required 0/00/0/00000000",
                     out_valid, out_ctrl, in_ready, out_data);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_ctrl !== 8'h03) begin
            n_fail++;
            $display("FAIL reset_first_entry: valid=%b data=%h ctrl=%h required 1/deadbeef/03",
                     out_valid, out_data, out_ctrl);
        end
        $display("test_reset: done, checks=%0d fails=%0d", n_checks, n_fail);
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1; stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = i; in_ctrl = 8'h01;
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== (i > 0) ||
                (i > 0 && (out_data !== DW'(i - 1) || out_ctrl !== 8'h01))) begin
                n_fail++;
                $display("FAIL stream_%0d: ready=%b valid=%b data=%h ctrl=%h required 1/%b/%h/01",
                         i, in_ready, out_valid, out_data, out_ctrl, i > 0, i - 1);
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd7) begin
            n_fail++;
            $display("FAIL stream_last: valid=%b data=%h required 1/00000007", out_valid, out_data);
        end
        tick();
        $display("test_streaming: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h02;
        tick();
        in_data = 32'h22; in_ctrl = 8'h04;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h11 || out_ctrl !== 8'h02) begin
            n_fail++;
            $display("FAIL skid_full: ready=%b valid=%b data=%h ctrl=%h required 0/1/11/02",
                     in_ready, out_valid, out_data, out_ctrl);
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h22 || out_ctrl !== 8'h04) begin
            n_fail++;
            $display("FAIL skid_second: ready=%b valid=%b data=%h ctrl=%h required 1/1/22/04",
                     in_ready, out_valid, out_data, out_ctrl);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
            n_fail++;
            $display("FAIL skid_drained: valid=%b ctrl=%h required 0/00", out_valid, out_ctrl);
        end
        $display("test_backpressure: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h33; in_ctrl = 8'h05;
        tick();
        in_valid = 1'b0; out_ready = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h33 || out_ctrl !== 8'h05 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: valid=%b data=%h ctrl=%h ready=%b required 1/33/05/1",
                         i, out_valid, out_data, out_ctrl, in_ready);
            end
            tick();
        end
        stall = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b required 0", out_valid);
        end
        $display("test_stall: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h44; in_ctrl = 8'h07;
        tick();
        in_data = 32'h55; in_ctrl = 8'h06;
        tick();
        flush = 1'b1; in_data = 32'h66; in_ctrl = 8'h01;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_empty: valid=%b ctrl=%h ready=%b required 0/00/1", out_valid, out_ctrl, in_ready);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h03;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h77 || out_ctrl !== 8'h03) begin
            n_fail++;
            $display("FAIL flush_resume: valid=%b data=%h ctrl=%h required 1/77/03", out_valid, out_data, out_ctrl);
        end
        tick();
        $display("test_flush: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        reset = 1'b1;
        q.delete(); m_stall = 0; m_bubble = 0;
        #1;
        n_checks++;
        if (stall_cnt !== 4'h0 || bubble_cnt !== 4'h0) begin
            n_fail++;
            $display("FAIL perf_reset: stall_cnt=%h bubble_cnt=%h required 0/0", stall_cnt, bubble_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if (bubble_cnt !== 4'd3 || bubble_cnt !== NW'(m_bubble)) begin
            n_fail++;
            $display("FAIL perf_bubble: bubble_cnt=%h required 3", bubble_cnt);
        end
        in_valid = 1'b1; in_data = 32'h99; in_ctrl = 8'h01;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        n_checks++;
        if (stall_cnt !== 4'hF || stall_cnt !== NW'(m_stall) || bubble_cnt !== NW'(m_bubble)) begin
            n_fail++;
            $display("FAIL perf_stall_sat: stall_cnt=%h bubble_cnt=%h required f/%h",
                     stall_cnt, bubble_cnt, m_bubble);
        end
        out_ready = 1'b1;
        tick();
        $display("test_perf: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_ctrl   = CW'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            n_checks++;
            if (in_ready !== m_ready() || out_valid !== m_valid() || out_ctrl !== m_ctrl() ||
                (m_valid() && out_data !== m_data())) begin
                n_fail++;
                $display("FAIL random_%0d: ready=%b valid=%b data=%h ctrl=%h required %b/%b/%h/%h",
                         c, in_ready, out_valid, out_data, out_ctrl, m_ready(), m_valid(), m_data(), m_ctrl());
            end
`ifdef PIPE_STAGE_PERF_EN
            n_checks++;
            if (stall_cnt !== NW'(m_stall) || bubble_cnt !== NW'(m_bubble)) begin
                n_fail++;
                $display("FAIL random_perf_%0d: stall_cnt=%h bubble_cnt=%h required %h/%h",
                         c, stall_cnt, bubble_cnt, m_stall, m_bubble);
            end
`endif
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; stall = 1'b0;
        $display("test_random: done, checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall();
        test_flush();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the pipelined CPU.
- Replaces the fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block carrying a DATA_W-bit payload and a CTRL_W-bit control bundle.
- Adds a valid/ready handshake, a 2-entry skid buffer, stall and flush.
- Flushed or empty slots always present all-zero control, so a bubble can never write the register file or memory.

Parameters:
DATA_W, 32, payload width (ALU result, memory data, PC+4, immediate, rd, … concatenated by the instantiating stage)
CTRL_W, 8, control-bit width (reg_wr, mem_reg, reg_in_sel, …); these bits are forced to zero in bubbles
CNT_W, 16, width of the performance counters (used only with PIPE_STAGE_PERF_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream has a valid entry
in_ready  out  1  stage can accept an entry this cycle
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bundle
stall  in  1  hazard-unit hold; blocks downstream transfer
flush  in  1  synchronous kill of all held entries (branch/jump redirect)
out_valid  out  1  a valid entry is presented downstream
out_ready  in  1  downstream accepts
out_data  out  DATA_W  presented payload
out_ctrl  out  CTRL_W  presented control; all zeros whenever out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and the transfer blocked (PIPE_STAGE_PERF_EN only)
bubble_cnt  out  CNT_W  cycles with out_valid=0 (PIPE_STAGE_PERF_EN only)

Behaviour:
- Reset: clk and reset as already decided (reset asynchronous, active-high; clock clk).
  - Reset clears all registers to 0 and puts the state in EMPTY.
  - While reset is high: out_valid=0, out_data=0, out_ctrl=0, in_ready=0.
- Handshake terms:
  - acc_in = in_valid & in_ready.
  - acc_out = out_valid & out_ready & ~stall.
- States: EMPTY (no entries), ONE (main slot valid), TWO (main and skid slots valid).
- in_ready = (state != TWO) & ~flush & ~reset. It depends only on state plus flush; there is no combinational path from out_ready.
- Transitions when flush=0:
  - EMPTY: acc_in → ONE, main ← in.
  - ONE: acc_in & acc_out → ONE, main ← in. acc_in only → TWO, skid ← in. acc_out only → EMPTY. Neither → hold.
  - TWO: acc_out → ONE, main ← skid. Otherwise hold. No input is accepted in TWO.
- Flush has the highest priority over all handshakes:
  - Next state is EMPTY; the main and skid ctrl registers are zeroed.
  - Data registers may keep stale values, but out_data is don't-care while out_valid=0.
  - No handshake completes in the flush cycle, because in_ready is forced to 0. An entry presented downstream in that cycle is still consumed if out_ready&~stall; downstream must qualify it with its own flush.
- Outputs:
  - out_valid = (state != EMPTY).
  - out_data = main_data.
  - out_ctrl = out_valid ? main_ctrl : 0.
- Latency: 1 cycle from acc_in to out_valid when EMPTY. Throughput is 1 per cycle with out_ready=1 and stall=0.
- Ordering is strictly FIFO: no entry is dropped or duplicated except on flush.
- stall=1 with out_ready=1: acts as out_ready=0. Outputs hold stable; in_ready stays 1 until TWO.
- Reset asserted mid-operation discards all entries immediately (asynchronous).

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle out_valid & ~(out_ready & ~stall).
  - bubble_cnt increments each cycle ~out_valid.
  - Both saturate at all-ones, clear on reset, and are unaffected by flush.
- Undefined: the counters and both ports are absent; the remaining behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - The state enum (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2).
  - Default width constants: DATA_W_DEF=32, CTRL_W_DEF=8, CNT_W_DEF=16.
  - CPU control-bundle bit-position constants (CTRL_REG_WR, CTRL_MEM_REG, CTRL_REG_IN_SEL), so stages pack and unpack consistently.
- One sub-module is natural: sat_counter (parametrised CNT_W, inc, clear), instantiated twice under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset with in_valid=1, in_data=32'hDEAD_BEEF, then release reset.
  - Required response: during reset out_valid=0, out_ctrl=0, in_ready=0. After release in_ready=1; the first edge captures the entry and out_data=32'hDEAD_BEEF next cycle.
- Streaming:
  - Stimulus: 8 back-to-back entries (data=0..7, ctrl=8'h01), out_ready=1, stall=0.
  - Required response: out_data 0..7 in order, one per cycle, starting 1 cycle after the first acc_in; in_ready stays 1.
- Backpressure and skid:
  - Stimulus: out_ready=0 while entries A=0x11 and B=0x22 arrive.
  - Required response: state reaches TWO and in_ready=0. Then out_ready=1: A is presented first, then B; in_ready returns to 1 the cycle after A transfers.
- Stall:
  - Stimulus: stall=1 with out_ready=1 for 3 cycles while holding entry 0x33, ctrl=8'h05.
  - Required response: out_data and out_ctrl hold 0x33/0x05 for the full 3 cycles; the entry transfers on the first cycle after stall drops.
- Flush in TWO:
  - Stimulus: pulse flush for 1 cycle with in_valid=1 in the same cycle.
  - Required response: next cycle out_valid=0 and out_ctrl=8'h00; the input is not accepted (in_ready=0 during flush); subsequent entries flow normally.
- Perf counters (PIPE_STAGE_PERF_EN, CNT_W=4):
  - Stimulus: hold the transfer blocked for 20 cycles.
  - Required response: stall_cnt saturates at 4'hF.
  - Stimulus: 3 idle cycles.
  - Required response: bubble_cnt increases by 3.
